alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the original eight operations (same encodings in the low three opcode bits) and adds subtract, variable-distance shifts and a signed multiply. The variable shifts and the multiply run as multi-cycle iterative operations. Operands enter through a valid/ready port and results leave through a registered valid/ready port, so the block can sit directly in the datapath of the lab processor's execute stage.

---
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with iterative shifts and multiply.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   in_valid/in_ready, a, b, s - operand/opcode request channel
//   out_valid/out_ready        - result channel
//   f, ovf, take_branch        - registered result, signed overflow, branch flag
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             take_branch
);

    localparam int CW  = SHW + 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000, OP_NOT  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
        OP_SRA  = 4'b0100, OP_SLL  = 4'b0101, OP_BEQ  = 4'b0110, OP_BNE  = 4'b0111,
        OP_SUB  = 4'b1000, OP_SRAV = 4'b1001, OP_SLLV = 4'b1010, OP_MUL  = 4'b1011
    } op_t;

    state_t               state, state_nxt;
    logic                 live;          // set on the first edge after reset release
    logic [WIDTH-1:0]     a_r, b_r;
    logic [3:0]           op_r;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 neg_r;

    logic                 accept, last;
    logic [WIDTH-1:0]     abs_a, abs_b, shift_step;
    logic [2*WIDTH-1:0]   acc_step, prod_s;
    logic [WIDTH-1:0]     res_f;
    logic                 res_ovf, res_tb;

    assign accept = in_valid && in_ready;
    // Final iteration happens on the edge that leaves EXEC, so cnt==1 is the
    // last working cycle and cnt==0 covers zero-length operations.
    assign last   = (cnt <= CW'(1));
    assign abs_a  = a[MSB] ? -a : a;
    assign abs_b  = b[MSB] ? -b : b;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state == IDLE) && live;
        out_valid = (state == DONE);
    end

    // One-step shift and multiply-accumulate values
    always_comb begin
        shift_step = (op_r == OP_SRAV) ? {a_r[MSB], a_r[MSB:1]} : {a_r[MSB-1:0], 1'b0};
        acc_step   = acc + (mplier[0] ? mcand : '0);
    end

    // Result selection for the final EXEC cycle
    always_comb begin
        res_f   = '0;
        res_ovf = 1'b0;
        res_tb  = 1'b0;
        prod_s  = '0;
        case (op_r)
            OP_ADD: begin
                res_f   = a_r + b_r;
                res_ovf = (a_r[MSB] == b_r[MSB]) && (res_f[MSB] != a_r[MSB]);
            end
            OP_SUB: begin
                res_f   = a_r - b_r;
                res_ovf = (a_r[MSB] != b_r[MSB]) && (res_f[MSB] != a_r[MSB]);
            end
            OP_NOT:  res_f = ~b_r;
            OP_AND:  res_f = a_r & b_r;
            OP_OR:   res_f = a_r | b_r;
            OP_SRA:  res_f = {a_r[MSB], a_r[MSB:1]};
            OP_SLL:  res_f = {a_r[MSB-1:0], 1'b0};
            OP_BEQ:  res_tb = (a_r == b_r);
            OP_BNE:  res_tb = (a_r != b_r);
            OP_SRAV, OP_SLLV: res_f = (cnt != '0) ? shift_step : a_r;
            OP_MUL: begin
                prod_s  = neg_r ? -acc_step : acc_step;
                res_f   = prod_s[MSB:0];
                res_ovf = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[MSB]}};
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            op_r        <= '0;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            neg_r       <= 1'b0;
            f           <= '0;
            ovf         <= 1'b0;
            take_branch <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_r    <= a;
                    b_r    <= b;
                    op_r   <= s;
                    acc    <= '0;
                    mcand  <= (2*WIDTH)'(abs_a);
                    mplier <= abs_b;
                    neg_r  <= a[MSB] ^ b[MSB];
                    if (s == OP_SRAV || s == OP_SLLV)
                        cnt <= CW'(b[SHW-1:0]);
                    else if (s == OP_MUL)
                        cnt <= CW'(WIDTH);
                    else
                        cnt <= '0;
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (op_r == OP_SRAV || op_r == OP_SLLV)
                            a_r <= shift_step;
                        if (op_r == OP_MUL) begin
                            acc    <= acc_step;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                        end
                    end
                    if (last) begin
                        f           <= res_f;
                        ovf         <= res_ovf;
                        take_branch <= res_tb;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8) with directed
// cases, randomized operations, backpressure and mid-operation reset.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         ovf;
    logic         take_branch;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .s           (s),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .f           (f),
        .ovf         (ovf),
        .take_branch (take_branch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model using plain signed integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  output logic [W-1:0] ef, output logic eovf, output logic etb,
                                  output int elat);
        int sa;
        int sb;
        int r;
        int n;
        sa   = int'($signed(xa));
        sb   = int'($signed(xb));
        n    = int'(xb[2:0]);
        r    = 0;
        ef   = '0;
        eovf = 1'b0;
        etb  = 1'b0;
        elat = 2;
        case (op)
            4'd0:  begin r = sa + sb; ef = r[W-1:0]; eovf = (r > 127) || (r < -128); end
            4'd1:  ef = ~xb;
            4'd2:  ef = xa & xb;
            4'd3:  ef = xa | xb;
            4'd4:  begin r = sa >>> 1; ef = r[W-1:0]; end
            4'd5:  begin r = sa * 2; ef = r[W-1:0]; end
            4'd6:  etb = (xa == xb);
            4'd7:  etb = (xa != xb);
            4'd8:  begin r = sa - sb; ef = r[W-1:0]; eovf = (r > 127) || (r < -128); end
            4'd9:  begin r = sa >>> n; ef = r[W-1:0]; elat = ((n > 1) ? n : 1) + 1; end
            4'd10: begin r = sa * (1 << n); ef = r[W-1:0]; elat = ((n > 1) ? n : 1) + 1; end
            4'd11: begin r = sa * sb; ef = r[W-1:0]; eovf = (r > 127) || (r < -128); elat = W + 1; end
            default: ;
        endcase
    endfunction

    // Issue one operation, measure latency, apply bp cycles of backpressure,
    // then retire it. Latency counts the accepting cycle as 1.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb, input int bp);
        logic [W-1:0] ef;
        logic         eovf, etb;
        int           elat, lat, guard;
        model(op, xa, xb, ef, eovf, etb, elat);
        @(negedge clk);
        in_valid = 1'b1; a = xa; b = xb; s = op;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); s = 4'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("op%0d_valid", op), 32'(out_valid), 32'd1);
        check($sformatf("op%0d_lat", op), 32'(lat), 32'(elat));
        check($sformatf("op%0d_f a=%0h b=%0h", op, xa, xb), 32'(f), 32'(ef));
        check($sformatf("op%0d_ovf a=%0h b=%0h", op, xa, xb), 32'(ovf), 32'(eovf));
        check($sformatf("op%0d_tb", op), 32'(take_branch), 32'(etb));
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); s = 4'($urandom);
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_f", 32'(f), 32'(ef));
            check("bp_ovf", 32'(ovf), 32'(eovf));
            check("bp_tb", 32'(take_branch), 32'(etb));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("retire_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
        check("retire_f_hold", 32'(f), 32'(ef));
        check("retire_ovf_hold", 32'(ovf), 32'(eovf));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; s = '0;
        #12;
        check("rst_f", 32'(f), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_tb", 32'(take_branch), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_in_ready_high", 32'(in_ready), 32'd1);

        // Directed cases
        do_op(4'b0000, 8'd100, 8'd50, 0);
        do_op(4'b1000, 8'h80,  8'd1,  0);
        do_op(4'b1011, 8'hF9,  8'd9,  0);
        do_op(4'b1011, 8'd20,  8'd10, 0);
        do_op(4'b1011, 8'h80,  8'hFF, 0);
        do_op(4'b1001, 8'h80,  8'd3,  0);
        do_op(4'b1010, 8'h81,  8'd0,  0);
        do_op(4'b1010, 8'h01,  8'd7,  0);
        do_op(4'b0110, 8'd5,   8'd5,  0);
        do_op(4'b0111, 8'd5,   8'd5,  0);
        do_op(4'b1101, 8'h5A,  8'hA5, 0);
        do_op(4'b0000, 8'd100, 8'd50, 5);
        do_op(4'b1011, 8'h80,  8'h80, 2);
        do_op(4'b1011, 8'h7F,  8'h7F, 1);

        // Randomized operations with random backpressure
        for (int i = 0; i < 120; i++)
            do_op(4'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));

        // Reset during a multiply: f is nonzero from the preceding ADD
        do_op(4'b0000, 8'd3, 8'd4, 0);
        @(negedge clk);
        in_valid = 1'b1; a = 8'h05; b = 8'h07; s = 4'b1011;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_f", 32'(f), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_release_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_result", 32'(out_valid), 32'd0);
        do_op(4'b0000, 8'd1, 8'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
